adc_snapshot_ctrl: RTL and testbench

Arms, triggers and sequences a single-shot capture of one RFDC ADC AXI-Stream (128-bit, 8 samples/beat) into a dual-port snapshot BRAM. It sits in the tile AXIS clock domain, between an RFDC tile output such as tile224_0 and the BRAM port A. Control inputs arrive already synchronised from the AXI-lite register bank, and the PS reads the BRAM through port B.

---
 rtl/adc_snapshot_pkg.sv | 14 +
 rtl/adc_snapshot_ctrl_edge_detect.sv | 22 ++
 rtl/adc_snapshot_ctrl.sv | 161 ++++++++++++++++
 tb/tb_adc_snapshot_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_snapshot_pkg.sv
// Shared types and constants for the ADC snapshot capture controller.
package adc_snapshot_pkg;

  localparam int STAMP_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_CAPTURE,
    S_DONE
  } state_e;

endpackage

// File: rtl/adc_snapshot_ctrl_edge_detect.sv
// Registered rising-edge detector: the output is high while the input is 1
// and its value on the previous clock was 0.
module edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/adc_snapshot_ctrl.sv
// Single-shot capture of an RFDC ADC AXI-Stream into snapshot BRAM port A:
// arm, wait for a trigger, skip a delay in beats, then store a fixed length.
module adc_snapshot_ctrl
  import adc_snapshot_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 10,
  parameter int DLY_W  = 16
) (
  input  logic               axis_input_clk,
  input  logic               axis_arst_n,
  input  logic [DATA_W-1:0]  s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               arm,
  input  logic               trig_src_sel,
  input  logic               ext_trig,
  input  logic [DLY_W-1:0]   trig_delay,
  input  logic [ADDR_W:0]    capture_len,
  output logic               bram_we,
  output logic [ADDR_W-1:0]  bram_addr,
  output logic [DATA_W-1:0]  bram_din,
  output logic               busy,
  output logic               done,
  output logic [STAMP_W-1:0] trig_stamp
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

  // Stream handshake: a beat transfers when tvalid is 1; tready is tied to 1
  // because the RFDC cannot be stalled, so every valid beat must be consumed.
  assign s_axis_tready = 1'b1;

  state_e              state_q, state_d;
  logic                src_sel_q, src_sel_d;
  logic [DLY_W-1:0]    dly_cnt_q, dly_cnt_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     wr_cnt_q, wr_cnt_d;
  logic [STAMP_W-1:0]  beat_cnt_q;
  logic [STAMP_W-1:0]  stamp_q, stamp_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ext_rise;
  logic                trig;
  logic [ADDR_W:0]     wr_cnt_inc;

  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] len);
    if (len == '0 || len > DEPTH) begin
      return DEPTH;
    end
    return len;
  endfunction

  edge_detect u_edge_detect (
    .clk_i  (axis_input_clk),
    .rst_ni (axis_arst_n),
    .sig_i  (ext_trig),
    .rise_o (ext_rise)
  );

  assign trig       = ~src_sel_q | ext_rise;
  assign wr_cnt_inc = wr_cnt_q + (ADDR_W+1)'(1);

  // The delay counter is loaded with the latched delay at arm and left
  // untouched in ARMED, so at the trigger it already holds the load value.
  always_comb begin
    state_d   = state_q;
    src_sel_d = src_sel_q;
    dly_cnt_d = dly_cnt_q;
    len_d     = len_q;
    wr_cnt_d  = wr_cnt_q;
    stamp_d   = stamp_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    din_d     = din_q;
    done_d    = done_q;

    if (arm) begin
      state_d   = S_ARMED;
      src_sel_d = trig_src_sel;
      dly_cnt_d = trig_delay;
      len_d     = clamp_len(capture_len);
      wr_cnt_d  = '0;
      done_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_ARMED: begin
          if (trig) begin
            stamp_d = beat_cnt_q;
            state_d = (dly_cnt_q == '0) ? S_CAPTURE : S_DELAY;
          end
        end
        S_DELAY: begin
          if (s_axis_tvalid) begin
            dly_cnt_d = dly_cnt_q - DLY_W'(1);
            if (dly_cnt_q == DLY_W'(1)) begin
              state_d = S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          if (s_axis_tvalid) begin
            we_d     = 1'b1;
            addr_d   = wr_cnt_q[ADDR_W-1:0];
            din_d    = s_axis_tdata;
            wr_cnt_d = wr_cnt_inc;
            if (wr_cnt_inc == len_q) begin
              state_d = S_DONE;
            end
          end
        end
        // done follows the DONE state by one cycle so it trails the last write.
        S_DONE:  done_d = 1'b1;
        default: state_d = state_q;
      endcase
    end

    busy_d = (state_d == S_ARMED) || (state_d == S_DELAY) || (state_d == S_CAPTURE);
  end

  always_ff @(posedge axis_input_clk or negedge axis_arst_n) begin
    if (!axis_arst_n) begin
      state_q    <= S_IDLE;
      src_sel_q  <= 1'b0;
      dly_cnt_q  <= '0;
      len_q      <= '0;
      wr_cnt_q   <= '0;
      beat_cnt_q <= '0;
      stamp_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_sel_q  <= src_sel_d;
      dly_cnt_q  <= dly_cnt_d;
      len_q      <= len_d;
      wr_cnt_q   <= wr_cnt_d;
      beat_cnt_q <= s_axis_tvalid ? beat_cnt_q + STAMP_W'(1) : beat_cnt_q;
      stamp_q    <= stamp_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bram_we    = we_q;
  assign bram_addr  = addr_q;
  assign bram_din   = din_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign trig_stamp = stamp_q;

endmodule

// File: tb/tb_adc_snapshot_ctrl.sv
// Directed bench for adc_snapshot_ctrl: immediate, external/delayed, gapped,
// clamped, re-armed and reset-interrupted captures against hand-derived values.
module tb_adc_snapshot_ctrl;
  import adc_snapshot_pkg::*;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 10;
  localparam int DLY_W  = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              arm;
  logic              trig_src_sel;
  logic              ext_trig;
  logic [DLY_W-1:0]  trig_delay;
  logic [ADDR_W:0]   capture_len;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              busy;
  logic              done;
  logic [31:0]       trig_stamp;

  adc_snapshot_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DLY_W(DLY_W)) dut (
    .axis_input_clk (clk),
    .axis_arst_n    (rst_n),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .arm            (arm),
    .trig_src_sel   (trig_src_sel),
    .ext_trig       (ext_trig),
    .trig_delay     (trig_delay),
    .capture_len    (capture_len),
    .bram_we        (bram_we),
    .bram_addr      (bram_addr),
    .bram_din       (bram_din),
    .busy           (busy),
    .done           (done),
    .trig_stamp     (trig_stamp)
  );

  int checks = 0;
  int errors = 0;
  int cyc_no = 0;
  logic [31:0] ramp;
  logic [31:0] stamp_exp;

  // write log and scoreboard
  logic [ADDR_W-1:0] wa_q[$];
  logic [DATA_W-1:0] wd_q[$];
  int                wc_q[$];
  logic [DATA_W-1:0] exp_q[$];

  always @(posedge clk) cyc_no <= cyc_no + 1;

  always @(negedge clk) begin
    if (bram_we === 1'b1) begin
      wa_q.push_back(bram_addr);
      wd_q.push_back(bram_din);
      wc_q.push_back(cyc_no);
    end
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one clock with the given tvalid; the ramp value is the beat index
  task automatic cyc(input logic v);
    s_axis_tvalid = v;
    s_axis_tdata  = {4{ramp}};
    @(posedge clk);
    #1;
    if (v) ramp = ramp + 32'd1;
    arm = 1'b0;
  endtask

  task automatic exp_ramp(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({4{first + 32'(i)}});
    end
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    exp_q.delete();
  endtask

  task automatic check_writes(input string tag, input int n, input int gap);
    chk($sformatf("%s_count", tag), DATA_W'(wd_q.size()), DATA_W'(n));
    for (int i = 0; i < n && i < wd_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), DATA_W'(wa_q[i]), DATA_W'(i));
      chk($sformatf("%s_data%0d", tag, i), wd_q[i], exp_q[i]);
      if (i > 0) chk($sformatf("%s_gap%0d", tag, i), DATA_W'(wc_q[i] - wc_q[i-1]), DATA_W'(gap));
    end
    clear_log();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},    DATA_W'(bram_we),    '0);
    chk({tag, "_addr"},  DATA_W'(bram_addr),  '0);
    chk({tag, "_din"},   bram_din,            '0);
    chk({tag, "_busy"},  DATA_W'(busy),       '0);
    chk({tag, "_done"},  DATA_W'(done),       '0);
    chk({tag, "_stamp"}, DATA_W'(trig_stamp), '0);
    chk({tag, "_state"}, DATA_W'(dut.state_q), DATA_W'(S_IDLE));
    chk({tag, "_tready"}, DATA_W'(s_axis_tready), DATA_W'(1));
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; trig_src_sel = 1'b0; ext_trig = 1'b0;
    trig_delay = '0; capture_len = '0; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    ramp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    cyc(0); cyc(0);
    chk("idle_hold", DATA_W'(dut.state_q), DATA_W'(S_IDLE));

    // immediate trigger, 16 beats continuous
    capture_len = 16; trig_delay = 0; trig_src_sel = 0; arm = 1;
    cyc(1);
    chk("imm_busy", DATA_W'(busy), DATA_W'(1));
    chk("imm_armed", DATA_W'(dut.state_q), DATA_W'(S_ARMED));
    stamp_exp = ramp;
    cyc(1);
    chk("imm_capture", DATA_W'(dut.state_q), DATA_W'(S_CAPTURE));
    chk("imm_stamp", DATA_W'(trig_stamp), DATA_W'(stamp_exp));
    exp_ramp(ramp, 16);
    repeat (15) cyc(1);
    chk("imm_not_done", DATA_W'(dut.state_q), DATA_W'(S_CAPTURE));
    cyc(1);
    chk("imm_state_done", DATA_W'(dut.state_q), DATA_W'(S_DONE));
    chk("imm_last_we", DATA_W'(bram_we), DATA_W'(1));
    chk("imm_last_addr", DATA_W'(bram_addr), DATA_W'(15));
    chk("imm_done_n1", DATA_W'(done), DATA_W'(0));
    cyc(0);
    chk("imm_done_n2", DATA_W'(done), DATA_W'(1));
    chk("imm_busy_off", DATA_W'(busy), DATA_W'(0));
    repeat (3) cyc(1);
    chk("imm_done_sticky", DATA_W'(done), DATA_W'(1));
    check_writes("imm", 16, 1);

    // external trigger, delay 5, length 4; inputs changed after arm
    trig_src_sel = 1; trig_delay = 5; capture_len = 4; arm = 1;
    cyc(1);
    chk("ext_done_clr", DATA_W'(done), DATA_W'(0));
    chk("ext_armed", DATA_W'(dut.state_q), DATA_W'(S_ARMED));
    trig_src_sel = 0; trig_delay = 0; capture_len = 100;
    repeat (3) cyc(1);
    chk("ext_wait", DATA_W'(dut.state_q), DATA_W'(S_ARMED));
    ext_trig = 1; stamp_exp = ramp;
    cyc(1);
    chk("ext_delay", DATA_W'(dut.state_q), DATA_W'(S_DELAY));
    chk("ext_stamp", DATA_W'(trig_stamp), DATA_W'(stamp_exp));
    repeat (4) cyc(1);
    chk("ext_delay4", DATA_W'(dut.state_q), DATA_W'(S_DELAY));
    cyc(1);
    chk("ext_capture", DATA_W'(dut.state_q), DATA_W'(S_CAPTURE));
    exp_ramp(ramp, 4);
    repeat (4) cyc(1);
    cyc(0);
    chk("ext_done", DATA_W'(done), DATA_W'(1));
    check_writes("ext", 4, 1);
    ext_trig = 0;

    // gapped valid, length 8
    trig_src_sel = 0; trig_delay = 0; capture_len = 8; arm = 1;
    cyc(1);
    cyc(1);
    exp_ramp(ramp, 8);
    repeat (8) begin cyc(1); cyc(0); end
    chk("gap_done", DATA_W'(done), DATA_W'(1));
    check_writes("gap", 8, 2);

    // length clamp: 0 and 2^ADDR_W + 3
    for (int k = 0; k < 2; k++) begin
      capture_len = (k == 0) ? 11'd0 : 11'd1027; arm = 1;
      cyc(1);
      cyc(1);
      exp_ramp(ramp, 1024);
      repeat (1023) cyc(1);
      chk("clamp_not_done", DATA_W'(dut.state_q), DATA_W'(S_CAPTURE));
      cyc(1);
      chk("clamp_state_done", DATA_W'(dut.state_q), DATA_W'(S_DONE));
      chk("clamp_last_addr", DATA_W'(bram_addr), DATA_W'(1023));
      cyc(0);
      chk("clamp_done", DATA_W'(done), DATA_W'(1));
      check_writes(k == 0 ? "clamp0" : "clamp1027", 1024, 1);
    end

    // re-arm after 10 of 64 beats
    capture_len = 64; arm = 1;
    cyc(1);
    cyc(1);
    repeat (10) cyc(1);
    arm = 1;
    cyc(1);
    chk("rearm_armed", DATA_W'(dut.state_q), DATA_W'(S_ARMED));
    chk("rearm_no_we", DATA_W'(bram_we), DATA_W'(0));
    chk("rearm_done", DATA_W'(done), DATA_W'(0));
    chk("rearm_busy", DATA_W'(busy), DATA_W'(1));
    chk("rearm_first_writes", DATA_W'(wd_q.size()), DATA_W'(10));
    clear_log();
    cyc(1);
    exp_ramp(ramp, 64);
    repeat (64) cyc(1);
    cyc(0);
    chk("rearm_done_end", DATA_W'(done), DATA_W'(1));
    check_writes("rearm", 64, 1);

    // arm and ext_trig edge in the same cycle: arm wins
    trig_src_sel = 1; trig_delay = 0; capture_len = 2; arm = 1; ext_trig = 1;
    cyc(1);
    chk("tie_armed", DATA_W'(dut.state_q), DATA_W'(S_ARMED));
    repeat (3) cyc(1);
    chk("tie_hold", DATA_W'(dut.state_q), DATA_W'(S_ARMED));
    chk("tie_busy", DATA_W'(busy), DATA_W'(1));
    ext_trig = 0;
    cyc(1);
    chk("tie_low", DATA_W'(dut.state_q), DATA_W'(S_ARMED));
    ext_trig = 1; stamp_exp = ramp;
    cyc(1);
    chk("tie_capture", DATA_W'(dut.state_q), DATA_W'(S_CAPTURE));
    chk("tie_stamp", DATA_W'(trig_stamp), DATA_W'(stamp_exp));
    exp_ramp(ramp, 2);
    repeat (2) cyc(1);
    cyc(0);
    chk("tie_done", DATA_W'(done), DATA_W'(1));
    check_writes("tie", 2, 1);
    ext_trig = 0;

    // asynchronous reset during CAPTURE
    trig_src_sel = 0; capture_len = 16; arm = 1;
    cyc(1);
    cyc(1);
    repeat (3) cyc(1);
    chk("prerst_we", DATA_W'(bram_we), DATA_W'(1));
    chk("prerst_state", DATA_W'(dut.state_q), DATA_W'(S_CAPTURE));
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("arst");
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_log();
    ramp = '0;
    rst_n = 1'b1;

    // beat counter restarts from 0 after reset
    capture_len = 1; arm = 1;
    cyc(1);
    cyc(1);
    chk("post_stamp", DATA_W'(trig_stamp), DATA_W'(1));
    exp_ramp(ramp, 1);
    cyc(1);
    cyc(0);
    chk("post_done", DATA_W'(done), DATA_W'(1));
    check_writes("post", 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
